// File: rtl/ins_decode_pipe_if.sv
// rtl/ins_decode_pipe_if.sv - instruction in / decoded entry out handshake bundle
interface ins_decode_pipe_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
);
    // Instruction side
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;

    // Decoded head entry side
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;

    // Statistics
    logic [CNT_W-1:0] decode_cnt;
    logic [CNT_W-1:0] illegal_cnt;

    // Fetch/execute side: supplies instructions, consumes decoded entries
    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, opcode, rd, funct3, rs1, rs2, funct7,
               imm, fmt, illegal, decode_cnt, illegal_cnt
    );

    // Decoder side
    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, opcode, rd, funct3, rs1, rs2, funct7,
               imm, fmt, illegal, decode_cnt, illegal_cnt
    );
endinterface

// File: rtl/ins_decode_pipe.sv
// rtl/ins_decode_pipe.sv - buffered RV32I/RV64I decoder with output FIFO and statistics
module ins_decode_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    ins_decode_pipe_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          last_q, last_d;
    entry_t          dec;
    entry_t          shown;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;

    logic            in_ready;
    logic            out_valid;
    logic            push;
    logic            pop;
    logic [31:0]     ins;

    assign ins       = bus.instruction;
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);

    // Flush wins over both handshakes; neither the FIFO nor the counters see them.
    assign push = bus.in_valid && in_ready && !flush;
    assign pop  = out_valid && bus.out_ready && !flush;

    // Split fields, classify the opcode and build the sign-extended immediate.
    always_comb begin
        dec         = '0;
        dec.opcode  = ins[6:0];
        dec.rd      = ins[11:7];
        dec.funct3  = ins[14:12];
        dec.rs1     = ins[19:15];
        dec.rs2     = ins[24:20];
        dec.funct7  = ins[31:25];
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
        // Every accepted opcode ends in 2'b11, so a compressed/reserved
        // encoding falls through to the illegal default on its own.
        case (ins[6:0])
            7'b0110011, 7'b0111011: begin
                dec.fmt     = FMT_R;
                dec.illegal = 1'b0;
            end
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.fmt     = FMT_I;
                dec.illegal = 1'b0;
                dec.imm     = {{(XLEN-12){ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                dec.fmt     = FMT_S;
                dec.illegal = 1'b0;
                dec.imm     = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                dec.fmt     = FMT_B;
                dec.illegal = 1'b0;
                dec.imm     = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25],
                               ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt     = FMT_U;
                dec.illegal = 1'b0;
                dec.imm     = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt     = FMT_J;
                dec.illegal = 1'b0;
                dec.imm     = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20],
                               ins[30:21], 1'b0};
            end
            default: begin
                dec.fmt     = FMT_ILL;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Next-state for pointers, occupancy, held output entry and statistics.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        dcnt_d   = dcnt_q;
        icnt_d   = icnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                last_d   = mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (push && (dcnt_q != '1)) begin
            dcnt_d = dcnt_q + 1'b1;
        end
        if (push && dec.illegal && (icnt_q != '1)) begin
            icnt_d = icnt_q + 1'b1;
        end
    end

    // Control and statistics registers; reset overrides flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            dcnt_q   <= '0;
            icnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            dcnt_q   <= dcnt_d;
            icnt_q   <= icnt_d;
        end
    end

    // Entry storage; contents are only visible through count, so no reset needed.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= dec;
        end
    end

    // Head entry while occupied, otherwise the last entry handed to execute.
    always_comb begin
        shown = last_q;
        if (out_valid) begin
            shown = mem_q[rd_ptr_q];
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.opcode      = shown.opcode;
    assign bus.rd          = shown.rd;
    assign bus.funct3      = shown.funct3;
    assign bus.rs1         = shown.rs1;
    assign bus.rs2         = shown.rs2;
    assign bus.funct7      = shown.funct7;
    assign bus.imm         = shown.imm;
    assign bus.fmt         = shown.fmt;
    assign bus.illegal     = shown.illegal;
    assign bus.decode_cnt  = dcnt_q;
    assign bus.illegal_cnt = icnt_q;
endmodule
